// File: rtl/reg_file_writeback.sv
// Write-back side of the 16 x 18-bit register file: accepts ALU or RAM-load writes,
// waits for load data with a timeout, and commits one register per request.
module reg_file_writeback #(
    parameter int DATA_W      = 18,
    parameter int NUM_REGS    = 16,
    parameter int RAM_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [3:0]                 wb_dst,
    input  logic                       wb_is_load,
    input  logic [DATA_W-1:0]          wb_alu_result,
    input  logic [DATA_W-1:0]          ram_data,
    input  logic                       ram_data_valid,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat,
    output logic [NUM_REGS-1:0]        write_strobe,
    output logic                       busy,
    output logic [3:0]                 busy_dst,
    output logic                       timeout_err
);

    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RAM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [3:0]          dst_q, dst_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic [NUM_REGS-1:0] strobe_q, strobe_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic accept;
    logic commit;

    assign accept = wb_valid && wb_ready;
    assign commit = (state_q == COMMIT);

    // State register and all other flops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            dst_q     <= '0;
            data_q    <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            strobe_q  <= '0;
            // NOTE: the register array is reset because the read side must see zeros after reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            dst_q     <= dst_d;
            data_q    <= data_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            strobe_q  <= strobe_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next-state logic plus request capture.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d   = state_q;
        dst_d     = dst_q;
        data_d    = data_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE, COMMIT: begin
                if (accept) begin
                    dst_d   = wb_dst;
                    data_d  = wb_alu_result;
                    timer_d = '0;
                    state_d = wb_is_load ? WAIT_RAM : COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RAM: begin
                if (ram_data_valid) begin
                    data_d  = ram_data;
                    state_d = COMMIT;
                end else if (timer_q == TMR_W'(RAM_TIMEOUT - 1)) begin
                    // The timer would reach RAM_TIMEOUT on this edge: abort without writing.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic and register-file write decode.
    always_comb begin
        ready_d  = 1'b1;
        wb_ready = ready_q && (state_q != WAIT_RAM);
        busy     = (state_q != IDLE);
        busy_dst = busy ? dst_q : 4'd0;
        strobe_d = commit ? (NUM_REGS'(1) << dst_q) : '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            regs_d[dst_q] = data_q;
        end
    end

    assign write_strobe = strobe_q;
    assign timeout_err  = timeout_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_reg_file_writeback.sv
// Bench for reg_file_writeback: directed requests feed an expected-write queue that a
// negedge monitor drains whenever the DUT raises write_strobe.
module tb_reg_file_writeback;

    localparam int DATA_W      = 18;
    localparam int NUM_REGS    = 16;
    localparam int RAM_TIMEOUT = 15;
    localparam int FW          = NUM_REGS * DATA_W;

    typedef struct packed {
        logic [3:0]        dst;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        wb_dst;
    logic              wb_is_load;
    logic [DATA_W-1:0] wb_alu_result;
    logic [DATA_W-1:0] ram_data;
    logic              ram_data_valid;
    logic [FW-1:0]     reg_flat;
    logic [NUM_REGS-1:0] write_strobe;
    logic              busy;
    logic [3:0]        busy_dst;
    logic              timeout_err;

    int n_vec = 0;
    int n_err = 0;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] model [NUM_REGS];

    always #5 clk = ~clk;

    reg_file_writeback #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RAM_TIMEOUT(RAM_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
        .wb_is_load(wb_is_load), .wb_alu_result(wb_alu_result),
        .ram_data(ram_data), .ram_data_valid(ram_data_valid),
        .reg_flat(reg_flat), .write_strobe(write_strobe),
        .busy(busy), .busy_dst(busy_dst), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
        return f;
    endfunction

    // Monitor: every strobe must match the oldest expected write, and the whole file must match.
    always @(negedge clk) begin
        wr_t e;
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (write_strobe != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", FW'(write_strobe), '0);
            end else begin
                e = exp_q.pop_front();
                model[e.dst] = e.data;
                check("strobe", FW'(write_strobe), FW'(16'(1) << e.dst));
                check("reg_flat", reg_flat, model_flat());
            end
        end
    end

    // Present a request and hold it until accepted (bounded).
    task automatic present(input logic [3:0] dst, input logic is_load, input logic [DATA_W-1:0] d);
        int waited = 0;
        wb_valid      = 1'b1;
        wb_dst        = dst;
        wb_is_load    = is_load;
        wb_alu_result = d;
        @(negedge clk);
        while (!wb_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!wb_ready) check("accept_timeout", FW'(wb_ready), FW'(1'b1));
        @(posedge clk);
        if (!is_load) exp_q.push_back('{dst: dst, data: d});
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; wb_valid = 1'b0; wb_dst = '0; wb_is_load = 1'b0;
        wb_alu_result = '0; ram_data = '0; ram_data_valid = 1'b0;

        // 1: reset state and wb_ready one edge after release
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_flat", reg_flat, '0);
        check("rst_ready", FW'(wb_ready), '0);
        check("rst_strobe", FW'(write_strobe), '0);
        check("rst_busy", FW'({busy, busy_dst, timeout_err}), '0);
        reset_n = 1'b1;
        #1;
        check("ready_before_clk", FW'(wb_ready), '0);
        tick();
        check("ready_after_clk", FW'(wb_ready), FW'(1'b1));

        // ram_data_valid while idle is ignored (monitor flags any strobe)
        ram_data = 18'h15555; ram_data_valid = 1'b1;
        tick(); tick();
        ram_data_valid = 1'b0;
        check("idle_ram_ignored", reg_flat, '0);

        // 2: ALU write R5
        present(4'd5, 1'b0, 18'h2A5A5);
        check("alu_busy", FW'({busy, busy_dst}), FW'(5'b1_0101));
        check("alu_not_yet", FW'(reg_flat[5*DATA_W +: DATA_W]), '0);
        tick();
        check("alu_r5", FW'(reg_flat[5*DATA_W +: DATA_W]), FW'(18'h2A5A5));
        tick();
        check("alu_strobe_gone", FW'(write_strobe), '0);
        check("alu_idle", FW'(busy), '0);

        // R0 is writable
        present(4'd0, 1'b0, 18'h12345);
        drain();

        // 3: load R15, data after 3 cycles
        present(4'd15, 1'b1, 18'h00000);
        check("load_busy_dst", FW'(busy_dst), FW'(4'd15));
        for (int i = 0; i < 3; i++) begin
            check("load_ready_low", FW'(wb_ready), '0);
            tick();
        end
        ram_data = 18'h3FFFF; ram_data_valid = 1'b1;
        exp_q.push_back('{dst: 4'd15, data: 18'h3FFFF});
        tick();
        ram_data_valid = 1'b0;
        check("load_commit_ready", FW'(wb_ready), FW'(1'b1));
        drain();
        check("load_r15", FW'(reg_flat[15*DATA_W +: DATA_W]), FW'(18'h3FFFF));

        // 4: load R2 times out after RAM_TIMEOUT cycles in WAIT_RAM
        present(4'd2, 1'b1, 18'h00000);
        for (int i = 0; i < RAM_TIMEOUT - 1; i++) tick();
        check("to_not_early", FW'({timeout_err, busy}), FW'(2'b01));
        tick();
        check("to_err", FW'(timeout_err), FW'(1'b1));
        check("to_idle", FW'({busy, wb_ready}), FW'(2'b01));
        check("to_r2", FW'(reg_flat[2*DATA_W +: DATA_W]), '0);
        tick(); tick();
        check("to_sticky", FW'(timeout_err), FW'(1'b1));

        // 5: back-to-back ALU writes to R3, second accepted in COMMIT
        present(4'd3, 1'b0, 18'h00001);
        check("b2b_ready_commit", FW'(wb_ready), FW'(1'b1));
        wb_valid = 1'b1; wb_dst = 4'd3; wb_is_load = 1'b0; wb_alu_result = 18'h00002;
        @(posedge clk);
        exp_q.push_back('{dst: 4'd3, data: 18'h00002});
        #1;
        wb_valid = 1'b0;
        check("b2b_first", FW'(reg_flat[3*DATA_W +: DATA_W]), FW'(18'h00001));
        tick();
        check("b2b_final", FW'(reg_flat[3*DATA_W +: DATA_W]), FW'(18'h00002));
        drain();

        // 6: reset during WAIT_RAM for R7 takes effect without a clock edge
        present(4'd7, 1'b1, 18'h00000);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_flat", reg_flat, '0);
        check("mid_rst_outs", FW'({wb_ready, busy, busy_dst, timeout_err, write_strobe}), '0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        present(4'd7, 1'b0, 18'h15555);
        drain();
        check("post_rst_r7", FW'(reg_flat[7*DATA_W +: DATA_W]), FW'(18'h15555));
        check("queue_empty", FW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
